fetch_stage: RTL and testbench

//   Holds the program counter and fetches one instruction at a time from instruction memory

---
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the program counter, reads one instruction
// at a time from instruction memory (req/ack) and presents it to decode
// (valid/ready). The next PC is supplied externally by the next-PC logic.
module fetch_stage #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int RESET_PC    = 0,
    parameter int TIMEOUT     = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   halt,
    input  logic [PC_WIDTH-1:0]    next_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [PC_WIDTH-1:0]    curr_pc,
    output logic                   fetch_fault
);

    // Timeout counter only has to reach TIMEOUT-1
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [TW-1:0]          tcnt;
    logic                   timeout_hit;
    logic                   handshake;

    assign timeout_hit = (tcnt == TW'(TIMEOUT - 1));
    assign handshake   = (state == HOLD) && instr_ready;

    assign imem_addr = pc;
    assign curr_pc   = pc;
    assign instr     = instr_q;

    // State register; reset abandons any in-flight fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived handshake outputs
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        case (state)
            IDLE: begin
                if (!halt) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = HOLD;
                end else if (timeout_hit) begin
                    state_nxt = FAULT;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = halt ? IDLE : FETCH;
                end
            end
            FAULT: begin
                fetch_fault = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture read data, count wait cycles, load PC on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_WIDTH'(RESET_PC);
            instr_q <= '0;
            tcnt    <= '0;
        end else begin
            if (state == FETCH) begin
                if (imem_ack) begin
                    instr_q <= imem_rdata;
                    tcnt    <= '0;
                end else if (!timeout_hit) begin
                    tcnt <= tcnt + TW'(1);
                end
            end
            if (handshake) begin
                pc <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle-stepped scenarios, with fetched
// instructions tracked through a scoreboard queue of {addr, data}.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic [7:0]  next_pc = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  curr_pc;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];

    fetch_stage #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (16),
        .RESET_PC    (0),
        .TIMEOUT     (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .halt        (halt),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .curr_pc     (curr_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Return memory data this cycle and record what decode should see
    task automatic issue_ack(input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        imem_ack   = 1'b1;
        imem_rdata = d;
        e.addr     = a;
        e.data     = d;
        sbq.push_back(e);
    endtask

    // Hold reset for two edges, then release just after an edge
    task automatic do_reset();
        rst_n       = 1'b0;
        halt        = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        next_pc     = 8'h00;
        imem_rdata  = 16'h0000;
        sbq.delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        checks++; if (imem_req !== 1'b0)    begin errors++; $display("[TB] FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault got=%b exp=0", fetch_fault); end
        checks++; if (curr_pc !== 8'h00)    begin errors++; $display("[TB] FAIL rst_pc got=%h exp=00", curr_pc); end
        checks++; if (instr !== 16'h0000)   begin errors++; $display("[TB] FAIL rst_instr got=%h exp=0000", instr); end
    endtask

    task automatic test_stream();
        exp_t e;
        do_reset();
        instr_ready = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1)      begin errors++; $display("[TB] FAIL stream_req i=%0d got=%b exp=1", i, imem_req); end
            checks++; if (imem_addr !== 8'(i))    begin errors++; $display("[TB] FAIL stream_addr got=%h exp=%h", imem_addr, 8'(i)); end
            issue_ack(8'(i), mem_word(8'(i)));
            next_pc = 8'(i + 1);
            step();
            imem_ack = 1'b0;
            checks++; if (instr_valid !== 1'b1)   begin errors++; $display("[TB] FAIL stream_valid i=%0d got=%b exp=1", i, instr_valid); end
            checks++; if (imem_req !== 1'b0)      begin errors++; $display("[TB] FAIL stream_req_low i=%0d got=%b exp=0", i, imem_req); end
            if (sbq.size() == 0) begin
                checks++; errors++; $display("[TB] FAIL stream_sb got=empty exp=entry");
            end else begin
                e = sbq.pop_front();
                checks++; if (instr !== e.data)   begin errors++; $display("[TB] FAIL stream_instr got=%h exp=%h", instr, e.data); end
                checks++; if (curr_pc !== e.addr) begin errors++; $display("[TB] FAIL stream_pc got=%h exp=%h", curr_pc, e.addr); end
            end
            step();
        end
    endtask

    task automatic test_wait_states();
        exp_t e;
        do_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1)    begin errors++; $display("[TB] FAIL wait_req i=%0d got=%b exp=1", i, imem_req); end
            checks++; if (imem_addr !== 8'h00)  begin errors++; $display("[TB] FAIL wait_addr got=%h exp=00", imem_addr); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_valid i=%0d got=%b exp=0", i, instr_valid); end
            step();
        end
        issue_ack(8'h00, 16'hA5C3);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL wait_early_valid got=%b exp=0", instr_valid); end
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wait_valid_after_ack got=%b exp=1", instr_valid); end
        if (sbq.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL wait_sb got=empty exp=entry");
        end else begin
            e = sbq.pop_front();
            checks++; if (instr !== e.data) begin errors++; $display("[TB] FAIL wait_instr got=%h exp=%h", instr, e.data); end
        end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = 16'hFFFF;
            checks++; if (instr !== 16'hA5C3)   begin errors++; $display("[TB] FAIL bp_instr i=%0d got=%h exp=a5c3", i, instr); end
            checks++; if (curr_pc !== 8'h00)    begin errors++; $display("[TB] FAIL bp_pc i=%0d got=%h exp=00", i, curr_pc); end
            checks++; if (imem_req !== 1'b0)    begin errors++; $display("[TB] FAIL bp_req i=%0d got=%b exp=0", i, imem_req); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid i=%0d got=%b exp=1", i, instr_valid); end
            step();
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        next_pc     = 8'h40;
        step();
        checks++; if (imem_req !== 1'b1)    begin errors++; $display("[TB] FAIL bp_next_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 8'h40)  begin errors++; $display("[TB] FAIL bp_next_addr got=%h exp=40", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_next_valid got=%b exp=0", instr_valid); end
    endtask

    task automatic test_wrap_halt();
        exp_t e;
        instr_ready = 1'b1;
        issue_ack(8'h40, mem_word(8'h40));
        next_pc = 8'hFF;
        step();
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid40 got=%b exp=1", instr_valid); end
        if (sbq.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL wrap_sb40 got=empty exp=entry");
        end else begin
            e = sbq.pop_front();
            checks++; if (instr !== e.data)   begin errors++; $display("[TB] FAIL wrap_instr40 got=%h exp=%h", instr, e.data); end
            checks++; if (curr_pc !== e.addr) begin errors++; $display("[TB] FAIL wrap_pc40 got=%h exp=%h", curr_pc, e.addr); end
        end
        step();
        checks++; if (imem_addr !== 8'hFF) begin errors++; $display("[TB] FAIL wrap_addr_ff got=%h exp=ff", imem_addr); end
        issue_ack(8'hFF, mem_word(8'hFF));
        next_pc     = 8'h00;
        instr_ready = 1'b0;
        step();
        imem_ack = 1'b0;
        if (sbq.size() == 0) begin
            checks++; errors++; $display("[TB] FAIL wrap_sbff got=empty exp=entry");
        end else begin
            e = sbq.pop_front();
            checks++; if (instr !== e.data)   begin errors++; $display("[TB] FAIL wrap_instrff got=%h exp=%h", instr, e.data); end
            checks++; if (curr_pc !== e.addr) begin errors++; $display("[TB] FAIL wrap_pcff got=%h exp=%h", curr_pc, e.addr); end
        end
        halt        = 1'b1;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        checks++; if (imem_addr !== 8'h00)  begin errors++; $display("[TB] FAIL wrap_addr00 got=%h exp=00", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_valid got=%b exp=0", instr_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req i=%0d got=%b exp=0", i, imem_req); end
            step();
        end
        halt = 1'b0;
        step();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("[TB] FAIL unhalt_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL unhalt_addr got=%h exp=00", imem_addr); end
    endtask

    task automatic test_timeout();
        do_reset();
        step();
        for (int i = 0; i < 15; i++) begin
            checks++; if (imem_req !== 1'b1)    begin errors++; $display("[TB] FAIL to_req i=%0d got=%b exp=1", i, imem_req); end
            checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL to_early_fault i=%0d got=%b exp=0", i, fetch_fault); end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL to_fault i=%0d got=%b exp=1", i, fetch_fault); end
            checks++; if (imem_req !== 1'b0)    begin errors++; $display("[TB] FAIL to_req_low i=%0d got=%b exp=0", i, imem_req); end
            checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL to_valid i=%0d got=%b exp=0", i, instr_valid); end
            imem_ack   = 1'b1;
            imem_rdata = 16'h1234;
            step();
        end
        imem_ack = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL to_clear got=%b exp=0", fetch_fault); end
    endtask

    task automatic test_async_reset();
        do_reset();
        instr_ready = 1'b1;
        step();
        imem_ack   = 1'b1;
        imem_rdata = mem_word(8'h00);
        next_pc    = 8'h20;
        step();
        imem_ack = 1'b0;
        step();
        checks++; if (imem_addr !== 8'h20) begin errors++; $display("[TB] FAIL ar_addr20 got=%h exp=20", imem_addr); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0)   begin errors++; $display("[TB] FAIL ar_fetch_req got=%b exp=0", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL ar_fetch_pc got=%h exp=00", imem_addr); end
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("[TB] FAIL ar_restart1_req got=%b exp=1", imem_req); end
        imem_ack    = 1'b1;
        imem_rdata  = 16'hBEEF;
        next_pc     = 8'h30;
        instr_ready = 1'b0;
        step();
        imem_ack = 1'b0;
        checks++; if (instr !== 16'hBEEF)  begin errors++; $display("[TB] FAIL ar_hold_instr got=%h exp=beef", instr); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_hold_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 16'h0000)   begin errors++; $display("[TB] FAIL ar_hold_instr_clr got=%h exp=0000", instr); end
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("[TB] FAIL ar_restart2_req got=%b exp=1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("[TB] FAIL ar_restart2_addr got=%h exp=00", imem_addr); end
    endtask

    // Scenario sequence; scoreboard must be drained at the end
    initial begin
        test_reset();
        test_stream();
        test_wait_states();
        test_backpressure();
        test_wrap_halt();
        test_timeout();
        test_async_reset();
        checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL sb_drain got=%0d exp=0", sbq.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
